// File: rtl/pc_jump_unit.sv
// Program counter with conditional/unconditional redirect resolution.
// A taken redirect that arrives while the pipeline is stalled is buffered
// and applied on the first unstalled edge. One redirect can be buffered.
// A one-cycle Flush pulse marks the cycle in which PC first shows a redirect
// target. A saturating counter tallies taken redirects for the debug display.
module pc_jump_unit #(
    parameter int PC_W     = 6,
    parameter int OFF_W    = 8,
    parameter int CNT_W    = 8,
    parameter int RESET_PC = 0
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic             Stall,
    input  logic             BrValid,
    output logic             BrReady,
    input  logic [1:0]       BrMode,
    input  logic             Zero,
    input  logic [OFF_W-1:0] BrOffset,
    input  logic [PC_W-1:0]  JTarget,
    output logic [PC_W-1:0]  PC,
    output logic [PC_W-1:0]  PCNext,
    output logic             Flush,
    output logic [CNT_W-1:0] TakenCnt
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    localparam logic [1:0] MODE_BEQ = 2'b00;
    localparam logic [1:0] MODE_BNE = 2'b01;
    localparam logic [1:0] MODE_JMP = 2'b11;

    state_t            state_q;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   pend_tgt_q;
    logic              flush_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   off_ext;
    logic [PC_W-1:0]   target;
    logic              accept;
    logic              cond_ok;
    logic              take;

    // Offset reduced to PC width: only its low PC_W bits matter when it is
    // wider than PC, otherwise it is sign-extended up to PC width.
    generate
        if (OFF_W >= PC_W) begin : g_off_trunc
            assign off_ext = BrOffset[PC_W-1:0];
        end else begin : g_off_sext
            assign off_ext = {{(PC_W-OFF_W){BrOffset[OFF_W-1]}}, BrOffset};
        end
    endgenerate

    assign pc_inc  = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    assign BrReady = (state_q == ST_IDLE);
    assign accept  = BrValid & BrReady;

    // Branch condition and redirect target; arithmetic wraps modulo 2^PC_W.
    always_comb begin
        cond_ok = 1'b1;
        if (BrMode == MODE_BEQ) begin
            cond_ok = Zero;
        end else if (BrMode == MODE_BNE) begin
            cond_ok = ~Zero;
        end
        take   = accept & cond_ok;
        target = (BrMode == MODE_JMP) ? JTarget : (pc_inc + off_ext);
    end

    // PC / redirect-buffer state machine with registered Flush pulse.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= ST_IDLE;
            pc_q       <= PC_W'(RESET_PC);
            pend_tgt_q <= '0;
            flush_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!Stall) begin
                        pc_q    <= take ? target : pc_inc;
                        flush_q <= take;
                    end else begin
                        flush_q <= 1'b0;
                        if (take) begin
                            pend_tgt_q <= target;
                            state_q    <= ST_PENDING;
                        end
                    end
                end
                ST_PENDING: begin
                    if (!Stall) begin
                        pc_q    <= pend_tgt_q;
                        flush_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        flush_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of taken redirects, counted at acceptance even if stalled.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            cnt_q <= '0;
        end else if (take && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign PC       = pc_q;
    assign PCNext   = pc_inc;
    assign Flush    = flush_q;
    assign TakenCnt = cnt_q;

endmodule

// File: tb/tb_pc_jump_unit.sv
// Directed bench for pc_jump_unit: a default instance (CNT_W=8) plus a
// CNT_W=2 instance sharing the same stimulus to exercise counter saturation.
module tb_pc_jump_unit;

    logic       Clk;
    logic       Resetn;
    logic       Stall;
    logic       BrValid;
    logic [1:0] BrMode;
    logic       Zero;
    logic [7:0] BrOffset;
    logic [5:0] JTarget;

    logic       BrReady;
    logic [5:0] PC;
    logic [5:0] PCNext;
    logic       Flush;
    logic [7:0] TakenCnt;

    logic       BrReady2;
    logic [5:0] PC2;
    logic [5:0] PCNext2;
    logic       Flush2;
    logic [1:0] TakenCnt2;

    int n_cmp = 0;
    int n_err = 0;

    pc_jump_unit #(.PC_W(6), .OFF_W(8), .CNT_W(8), .RESET_PC(0)) dut (
        .Clk(Clk), .Resetn(Resetn), .Stall(Stall), .BrValid(BrValid),
        .BrReady(BrReady), .BrMode(BrMode), .Zero(Zero), .BrOffset(BrOffset),
        .JTarget(JTarget), .PC(PC), .PCNext(PCNext), .Flush(Flush),
        .TakenCnt(TakenCnt)
    );

    pc_jump_unit #(.PC_W(6), .OFF_W(8), .CNT_W(2), .RESET_PC(0)) dut_sat (
        .Clk(Clk), .Resetn(Resetn), .Stall(Stall), .BrValid(BrValid),
        .BrReady(BrReady2), .BrMode(BrMode), .Zero(Zero), .BrOffset(BrOffset),
        .JTarget(JTarget), .PC(PC2), .PCNext(PCNext2), .Flush(Flush2),
        .TakenCnt(TakenCnt2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic br(input logic [1:0] m, input logic z, input logic [7:0] off, input logic [5:0] jt);
        BrValid  = 1'b1;
        BrMode   = m;
        Zero     = z;
        BrOffset = off;
        JTarget  = jt;
    endtask

    task automatic nobr();
        BrValid  = 1'b0;
        BrMode   = 2'b00;
        Zero     = 1'b0;
        BrOffset = 8'h00;
        JTarget  = 6'd0;
    endtask

    initial begin
        Resetn = 1'b0;
        Stall  = 1'b0;
        nobr();

        // 1. Reset state and sequential counting
        #12;
        chk("rst_pc", PC, 0);
        chk("rst_flush", Flush, 0);
        chk("rst_cnt", TakenCnt, 0);
        chk("rst_ready", BrReady, 1);
        chk("rst_pcnext", PCNext, 1);
        Resetn = 1'b1;
        tick(); chk("seq_pc1", PC, 1);
        tick(); chk("seq_pc2", PC, 2);
        tick(); chk("seq_pc3", PC, 3);
        #2 Resetn = 1'b0;
        #1 chk("async_rst_pc", PC, 0);
        Resetn = 1'b1;
        chk("async_rst_pc2", PC, 0);

        // 2. BEQ / BNE from PC=15 with offset 9
        br(2'b11, 1'b0, 8'h00, 6'd15); tick();
        chk("jmp15_pc", PC, 15);
        chk("jmp15_flush", Flush, 1);
        chk("jmp15_cnt", TakenCnt, 1);
        br(2'b00, 1'b1, 8'd9, 6'd0); tick();
        chk("beq_t_pc", PC, 25);
        chk("beq_t_flush", Flush, 1);
        chk("beq_t_cnt", TakenCnt, 2);
        br(2'b11, 1'b0, 8'h00, 6'd15); tick();              // cnt 3
        br(2'b00, 1'b0, 8'd9, 6'd0); tick();
        chk("beq_nt_pc", PC, 16);
        chk("beq_nt_flush", Flush, 0);
        chk("beq_nt_cnt", TakenCnt, 3);
        br(2'b11, 1'b0, 8'h00, 6'd15); tick();              // cnt 4
        br(2'b01, 1'b0, 8'd9, 6'd0); tick();
        chk("bne_t_pc", PC, 25);
        chk("bne_t_cnt", TakenCnt, 5);
        chk("sat_cnt", TakenCnt2, 3);

        // 3. Wrap-around
        br(2'b11, 1'b0, 8'h00, 6'd63); tick();              // cnt 6
        chk("jmp63_pcnext", PCNext, 0);
        nobr(); tick();
        chk("wrap_seq_pc", PC, 0);
        br(2'b11, 1'b0, 8'h00, 6'd62); tick();              // cnt 7
        br(2'b10, 1'b0, 8'h05, 6'd0); tick();               // cnt 8
        chk("wrap_rel_pc", PC, 4);
        br(2'b11, 1'b0, 8'h00, 6'd62); tick();              // cnt 9
        br(2'b10, 1'b0, 8'hFC, 6'd0); tick();               // cnt 10
        chk("neg_rel_pc", PC, 59);
        chk("neg_rel_cnt", TakenCnt, 10);

        // 4. Stalled redirect
        br(2'b11, 1'b0, 8'h00, 6'd15); tick();              // cnt 11
        Stall = 1'b1;
        br(2'b00, 1'b1, 8'd9, 6'd0); tick();                // cnt 12, buffered
        chk("stall_pc", PC, 15);
        chk("stall_ready", BrReady, 0);
        chk("stall_flush", Flush, 0);
        chk("stall_cnt", TakenCnt, 12);
        br(2'b11, 1'b0, 8'h00, 6'd5); tick();               // ignored
        chk("stall2_pc", PC, 15);
        chk("stall2_cnt", TakenCnt, 12);
        Stall = 1'b0;                                       // new BrValid still present, not accepted
        tick();
        chk("unstall_pc", PC, 25);
        chk("unstall_flush", Flush, 1);
        chk("unstall_cnt", TakenCnt, 12);
        chk("unstall_ready", BrReady, 1);
        nobr(); tick();
        chk("post_pc", PC, 26);
        chk("post_flush", Flush, 0);

        // 5. Absolute jump
        br(2'b11, 1'b1, 8'h33, 6'd42); tick();              // cnt 13
        chk("abs_pc", PC, 42);
        chk("abs_cnt", TakenCnt, 13);

        // 6. Reset while a redirect is buffered
        Stall = 1'b1;
        br(2'b11, 1'b0, 8'h00, 6'd50); tick();              // cnt 14
        chk("pend_ready", BrReady, 0);
        chk("pend_cnt", TakenCnt, 14);
        nobr();
        #2 Resetn = 1'b0;
        #1 chk("mid_rst_pc", PC, 0);
        chk("mid_rst_ready", BrReady, 1);
        chk("mid_rst_cnt", TakenCnt, 0);
        Stall  = 1'b0;
        Resetn = 1'b1;
        tick();
        chk("after_rst_pc1", PC, 1);
        chk("after_rst_fl1", Flush, 0);
        tick();
        chk("after_rst_pc2", PC, 2);
        chk("after_rst_fl2", Flush, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_jump_unit.md
Name: pc_jump_unit

Overview:
Parametrised program-counter and conditional-jump unit for the single-cycle/multicycle MIPS datapath. It holds the registered PC and produces the sequential successor PCNext. It resolves BEQ, BNE, unconditional-relative and absolute-jump redirects against the ALU Zero flag, and buffers one redirect while the pipeline is stalled. It also emits a one-cycle Flush pulse and a saturating taken-branch counter for the debug display.

Parameters:
PC_W, 6, PC width in word addresses; all PC arithmetic is modulo 2^PC_W.
OFF_W, 8, branch offset width; the offset is a signed, already word-scaled value.
CNT_W, 8, width of the taken-branch counter.
RESET_PC, 0, PC value loaded on reset.

Ports:
Clk  in  1  system clock; all state updates on the rising edge.
Resetn  in  1  asynchronous active-low reset.
Stall  in  1  when 1, PC holds its value.
BrValid  in  1  a branch or jump is presented this cycle.
BrReady  out  1  unit can accept a branch; BrReady = !pending.
BrMode  in  2  00 BEQ (taken if Zero=1), 01 BNE (taken if Zero=0), 10 relative unconditional, 11 absolute jump.
Zero  in  1  ALU zero flag, sampled in the accept cycle only.
BrOffset  in  OFF_W  signed offset relative to PCNext.
JTarget  in  PC_W  absolute target for mode 11.
PC  out  PC_W  current registered PC.
PCNext  out  PC_W  PC+1 mod 2^PC_W, combinational from PC.
Flush  out  1  registered; high for one cycle after PC is loaded with a redirect target.
TakenCnt  out  CNT_W  count of taken redirects, saturating.

Behaviour:
- Reset (Resetn=0, asynchronous):
  - PC=RESET_PC, Flush=0, TakenCnt=0.
  - pending=0, so BrReady=1.
  - Pending target is cleared. A reset mid-pending discards the buffered redirect.
- Accept: accept = BrValid & BrReady.
- Taken condition: take = accept & (mode00 ? Zero : mode01 ? !Zero : 1).
- Target:
  - Modes 00/01/10: PCNext + sext(BrOffset), result truncated to PC_W bits (wraps mod 2^PC_W).
  - If OFF_W > PC_W, only the low PC_W bits of the offset matter.
  - Mode 11: target = JTarget.
- A branch accepted but not taken has no effect beyond consuming the cycle's BrValid.
- States:
  - IDLE (pending=0), PENDING (pending=1).
  - IDLE, Stall=0: PC <= take ? target : PCNext; Flush <= take.
  - IDLE, Stall=1: PC holds, Flush <= 0. If take, latch the target into PendTgt and go to PENDING.
  - PENDING, Stall=1: PC holds, Flush <= 0. BrReady=0, so BrValid is ignored (not accepted, not counted).
  - PENDING, Stall=0: PC <= PendTgt, Flush <= 1, go to IDLE. BrReady returns to 1 the following cycle.
- Redirect latency: PC shows the target on the first rising edge with Stall=0 at or after acceptance. Flush is high exactly the cycle PC first shows the target.
- TakenCnt increments by 1 in the cycle take=1, whether or not stalled. It holds at 2^CNT_W-1.
- Zero and BrOffset are not re-sampled while PENDING; the buffered target is frozen.
- Simultaneous Stall deassert and new BrValid while PENDING: the new branch is not accepted (BrReady=0 that cycle).
- No X propagation: with BrValid=0, BrMode, Zero, BrOffset and JTarget are don't-care.

Test Plan:
1. Reset and sequential:
   - Hold Resetn=0 → PC=0, Flush=0, TakenCnt=0, BrReady=1.
   - Release with Stall=0, BrValid=0 → PC 0,1,2,3 on successive edges.
   - Assert Resetn=0 asynchronously mid-cycle → PC=0 immediately.
2. BEQ/BNE at PC=15 (PCNext=16), BrOffset=9:
   - Mode 00, Zero=1 → PC=25, Flush=1 that cycle, TakenCnt=1.
   - Mode 00, Zero=0 → PC=16, Flush=0.
   - Mode 01, Zero=0 → PC=25.
3. Wrap-around:
   - PC=63, no branch → PC=0.
   - PC=62, BrOffset=8'h05, mode 10 → PC=4 (63+5 mod 64).
   - PC=62, BrOffset=8'hFC → PC=59.
4. Stalled redirect:
   - Stall=1, PC=15, mode 00, Zero=1, BrOffset=9 → PC holds 15, BrReady=0 next cycle, TakenCnt=1.
   - Second BrValid (mode 11, JTarget=5) during stall → ignored.
   - Drop Stall → PC=25, Flush=1, BrReady=1 one cycle later.
5. Absolute jump and saturation:
   - Mode 11, JTarget=42 → PC=42.
   - With CNT_W=2, five taken branches → TakenCnt=3.
6. Reset mid-pending:
   - Enter PENDING, assert Resetn=0, release with Stall=0 → PC counts from 0, the buffered target is never loaded, and Flush stays 0.
